md_unit_ctrl: RTL and testbench

Multiply/divide unit sequencer for the pipelined CPU's execute stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from EX and models a fixed multi-cycle latency with a busy counter. It owns the HI/LO registers and drives the 2:1 HI/LO read select that feeds MFHI/MFLO results back into the datapath. It also produces the stall request the hazard unit uses to hold MD-dependent instructions in decode.

---
 rtl/md_unit_ctrl_if.sv | 35 +++
 rtl/md_unit_ctrl.sv | 174 +++++++++++++++++
 tb/tb_md_unit_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_ctrl_if.sv
// md_unit_ctrl_if
//   Command / result bundle between the execute stage and the multiply/divide
//   sequencer.
//   master : execute stage side (drives start/op/a/b/rd_sel)
//   slave  : md_unit_ctrl side (drives busy/stall_req/hi/lo/rd_data)
//   start     command valid this cycle
//   op[2:0]   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   a, b      rs / rt operands
//   rd_sel    0 reads LO, 1 reads HI onto rd_data
//   busy      mult/div in flight (registered)
//   stall_req hazard-unit stall request (combinational)
//   hi, lo    architectural HI/LO registers
//   rd_data   rd_sel ? hi : lo (combinational)
interface md_unit_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_sel;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    modport master (
        output start, op, a, b, rd_sel,
        input  busy, stall_req, hi, lo, rd_data
    );

    modport slave (
        input  start, op, a, b, rd_sel,
        output busy, stall_req, hi, lo, rd_data
    );
endinterface

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl
//   Multiply/divide sequencer for the execute stage. Accepts MULT/MULTU/
//   DIV/DIVU/MTHI/MTLO, models a fixed multi-cycle latency with a down
//   counter, owns HI/LO and provides the HI/LO read mux and the MD stall
//   request for the hazard unit.
//   Parameters:
//     MULT_CYCLES  busy cycles for MULT/MULTU (1..15)
//     DIV_CYCLES   busy cycles for DIV/DIVU   (1..15)
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     md     md_unit_ctrl_if.slave command/result bundle
module md_unit_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    md_unit_ctrl_if.slave        md
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic [1:0]  op_q;      // op[2] is always 0 for an accepted mult/div
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        is_md;
    logic        accept;
    logic        finish;

    // Result datapath, evaluated from the latched operands
    logic        sgn;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] dvsr;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        res_wr;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign is_md = md.start & ~md.op[2];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (is_md) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Arithmetic on latched operands. Signed division is done on
    // magnitudes and the signs reapplied, which makes
    // 0x80000000 / -1 come out as lo=0x80000000, hi=0 without relying
    // on tool-specific overflow behaviour.
    // ------------------------------------------------------------------
    always_comb begin
        sgn    = ~op_q[0];
        ext_a  = {{32{sgn & a_q[31]}}, a_q};
        ext_b  = {{32{sgn & b_q[31]}}, b_q};
        prod   = ext_a * ext_b;

        mag_a  = (sgn && a_q[31]) ? (32'd0 - a_q) : a_q;
        mag_b  = (sgn && b_q[31]) ? (32'd0 - b_q) : b_q;
        // Divisor forced non-zero so the divider never sees 0; the
        // result is discarded in that case anyway.
        dvsr   = (b_q == 32'd0) ? 32'd1 : mag_b;
        uq     = mag_a / dvsr;
        ur     = mag_a % dvsr;
        quo    = (sgn && (a_q[31] ^ b_q[31])) ? (32'd0 - uq) : uq;
        rem    = (sgn && a_q[31]) ? (32'd0 - ur) : ur;

        if (!op_q[1]) begin
            res_wr = 1'b1;
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end else begin
            res_wr = (b_q != 32'd0);
            res_hi = rem;
            res_lo = quo;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            if (accept) begin
                op_q  <= md.op[1:0];
                a_q   <= md.a;
                b_q   <= md.b;
                cnt_q <= md.op[1] ? DIV_LOAD : MULT_LOAD;
            end else if (state_q == BUSY && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end

            if (finish) begin
                if (res_wr) begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                end
            end else if (state_q == IDLE && md.start) begin
                // MTHI/MTLO only land in IDLE; while BUSY they are dropped.
                if (md.op == 3'b100) begin
                    hi_q <= md.a;
                end else if (md.op == 3'b101) begin
                    lo_q <= md.a;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign md.busy      = (state_q == BUSY);
    assign md.stall_req = (state_q == BUSY) | is_md;
    assign md.hi        = hi_q;
    assign md.lo        = lo_q;
    assign md.rd_data   = md.rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl
//   Scoreboard bench for md_unit_ctrl: expected HI/LO are pushed when a
//   mult/div is issued and popped when busy drops.
module tb_md_unit_ctrl;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    md_unit_ctrl_if mdif();

    md_unit_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .md   (mdif)
    );

    res_t        sb[$];
    logic [31:0] mhi;
    logic [31:0] mlo;
    int          n_pass;
    int          n_checks;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one mult/div and walk through its busy window. Optionally
    // drives an extra start in busy cycle ign_cyc that must be ignored.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic wr, input logic [31:0] ehi, input logic [31:0] elo,
                         input int n, input int ign_cyc,
                         input logic [2:0] ign_op, input logic [31:0] ign_a);
        res_t r;
        mdif.start = 1'b1;
        mdif.op    = op;
        mdif.a     = a;
        mdif.b     = b;
        #1;
        check("stall_accept", mdif.stall_req, 1);
        check("busy_accept", mdif.busy, 0);
        r.hi = wr ? ehi : mhi;
        r.lo = wr ? elo : mlo;
        sb.push_back(r);
        step();
        mdif.start = 1'b0;
        mdif.a     = 32'hDEAD_BEEF;
        mdif.b     = 32'h0BAD_F00D;
        for (int i = 1; i <= n; i++) begin
            if (i == ign_cyc) begin
                mdif.start = 1'b1;
                mdif.op    = ign_op;
                mdif.a     = ign_a;
                #1;
            end
            check("busy_run", mdif.busy, 1);
            check("stall_run", mdif.stall_req, 1);
            check("hi_hold", mdif.hi, mhi);
            check("lo_hold", mdif.lo, mlo);
            step();
            mdif.start = 1'b0;
        end
        #1;
        check("busy_done", mdif.busy, 0);
        check("stall_done", mdif.stall_req, 0);
        if (sb.size() == 0) begin
            check("sb_underflow", 0, 1);
        end else begin
            r = sb.pop_front();
            check("hi_result", mdif.hi, r.hi);
            check("lo_result", mdif.lo, r.lo);
            mhi = r.hi;
            mlo = r.lo;
        end
    endtask

    initial begin
        n_pass      = 0;
        n_checks    = 0;
        mhi         = '0;
        mlo         = '0;
        rst_n       = 1'b0;
        mdif.start  = 1'b1;
        mdif.op     = 3'b000;
        mdif.a      = 32'd5;
        mdif.b      = 32'd6;
        mdif.rd_sel = 1'b0;

        // Reset with a MULT request held: nothing may be accepted
        step();
        step();
        check("rst_busy", mdif.busy, 0);
        check("rst_hi", mdif.hi, 0);
        check("rst_lo", mdif.lo, 0);
        check("rst_stall_start", mdif.stall_req, 1);
        mdif.start = 1'b0;
        #1;
        check("rst_stall_idle", mdif.stall_req, 0);
        rst_n = 1'b1;
        step();
        check("post_rst_busy", mdif.busy, 0);

        // MULT -2 * 3
        issue(3'b000, 32'hFFFF_FFFE, 32'd3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 0, 3'b000, '0);
        // MULTU 0xFFFFFFFF^2
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 5, 0, 3'b000, '0);
        // DIV -7 / 2 with an MTHI dropped at busy cycle 3
        issue(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 3, 3'b100, 32'h1234);

        // MTLO immediately at completion+1
        mdif.start = 1'b1;
        mdif.op    = 3'b101;
        mdif.a     = 32'hABCD;
        #1;
        check("stall_mtlo", mdif.stall_req, 0);
        step();
        mdif.start = 1'b0;
        mlo = 32'hABCD;
        check("lo_mtlo", mdif.lo, mlo);
        check("hi_after_mtlo", mdif.hi, mhi);
        check("busy_mtlo", mdif.busy, 0);

        // DIVU by zero: HI/LO keep their values
        issue(3'b011, 32'd7, 32'd0, 1'b0, '0, '0, 10, 0, 3'b000, '0);
        // DIVU 100 / 7
        issue(3'b011, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 10, 0, 3'b000, '0);
        // DIV overflow case, with a MULT start in the completion cycle
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000, 10, 10, 3'b000, 32'd9);
        step();
        check("b2b_ignored", mdif.busy, 0);

        // MTHI, then rd_data mux
        mdif.start = 1'b1;
        mdif.op    = 3'b100;
        mdif.a     = 32'h55AA;
        step();
        mdif.start = 1'b0;
        mhi = 32'h55AA;
        check("hi_mthi", mdif.hi, mhi);
        mdif.rd_sel = 1'b0;
        #1;
        check("rd_lo", mdif.rd_data, mlo);
        mdif.rd_sel = 1'b1;
        #1;
        check("rd_hi", mdif.rd_data, mhi);
        mdif.rd_sel = 1'b0;
        #1;
        check("rd_lo_again", mdif.rd_data, mlo);

        // Reserved op: no effect
        mdif.start = 1'b1;
        mdif.op    = 3'b110;
        mdif.a     = 32'h7777;
        #1;
        check("stall_rsvd", mdif.stall_req, 0);
        step();
        mdif.start = 1'b0;
        check("busy_rsvd", mdif.busy, 0);
        check("hi_rsvd", mdif.hi, mhi);
        check("lo_rsvd", mdif.lo, mlo);

        // Reset in busy cycle 2 of MULT 5*6: 30 never appears
        mdif.start = 1'b1;
        mdif.op    = 3'b000;
        mdif.a     = 32'd5;
        mdif.b     = 32'd6;
        step();
        mdif.start = 1'b0;
        check("mid_busy1", mdif.busy, 1);
        step();
        check("mid_busy2", mdif.busy, 1);
        rst_n = 1'b0;
        step();
        check("mid_rst_busy", mdif.busy, 0);
        check("mid_rst_hi", mdif.hi, 0);
        check("mid_rst_lo", mdif.lo, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("no_stale_lo", mdif.lo, 0);
            check("no_stale_busy", mdif.busy, 0);
        end
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
